// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the data cache.
// State encoding, address field widths and their derivation.
package dcache_pkg;

    localparam int OFFSET_W   = 5;
    localparam int WORD_SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_e;

    function automatic int index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int num_lines);
        return addr_w - index_w(num_lines) - OFFSET_W;
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag, valid, dirty and data storage for a direct-mapped cache.
// Async read by index, sync line refill or single-word update.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int INDEX_W   = 4,
    parameter int TAG_W     = 23,
    parameter int BLOCK_W   = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEX_W-1:0]    index,
    output logic                  valid,
    output logic                  dirty,
    output logic [TAG_W-1:0]      tag,
    output logic [BLOCK_W-1:0]    data,
    input  logic                  refill_we,
    input  logic [TAG_W-1:0]      refill_tag,
    input  logic [BLOCK_W-1:0]    refill_data,
    input  logic                  word_we,
    input  logic [WORD_SEL_W-1:0] word_sel,
    input  logic [31:0]           word_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [BLOCK_W-1:0]   data_q [NUM_LINES];

    assign valid = valid_q[index];
    assign dirty = dirty_q[index];
    assign tag   = tag_q[index];
    assign data  = data_q[index];

    // Line status: refill makes a line clean, a word store makes it dirty.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (refill_we) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (word_we) begin
            dirty_q[index] <= 1'b1;
        end
    end

    // Payload: whole-line refill or one 32-bit word merge.
    always_ff @(posedge clk_i) begin
        if (refill_we) begin
            tag_q[index]  <= refill_tag;
            data_q[index] <= refill_data;
        end else if (word_we) begin
            data_q[index][32*word_sel +: 32] <= word_data;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back write-allocate data cache controller.
// Hits are combinational; misses stall the pipeline until refilled.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int NUM_LINES = 16,
    parameter int BLOCK_W   = 256
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cpu_req_i,
    input  logic               cpu_write_i,
    input  logic [ADDR_W-1:0]  cpu_addr_i,
    input  logic [31:0]        cpu_wdata_i,
    output logic [31:0]        cpu_rdata_o,
    output logic               cpu_stall_o,
    output logic               mem_enable_o,
    output logic               mem_write_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [BLOCK_W-1:0] mem_data_o,
    input  logic [BLOCK_W-1:0] mem_data_i,
    input  logic               mem_ack_i
);

    localparam int INDEX_W = index_w(NUM_LINES);
    localparam int TAG_W   = tag_w(ADDR_W, NUM_LINES);

    state_e state;

    logic [INDEX_W-1:0]    index;
    logic [TAG_W-1:0]      req_tag;
    logic [WORD_SEL_W-1:0] word_sel;
    logic [1:0]            unused_byte;

    logic                  line_valid;
    logic                  line_dirty;
    logic [TAG_W-1:0]      line_tag;
    logic [BLOCK_W-1:0]    line_data;

    logic                  hit;
    logic                  refill_we;
    logic                  word_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [ADDR_W-1:0]     victim_addr;

    assign index       = cpu_addr_i[OFFSET_W +: INDEX_W];
    assign req_tag     = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign word_sel    = cpu_addr_i[2 +: WORD_SEL_W];
    assign unused_byte = cpu_addr_i[1:0];

    assign hit         = line_valid & (line_tag == req_tag);
    assign req_addr    = {req_tag, index, {OFFSET_W{1'b0}}};
    assign victim_addr = {line_tag, index, {OFFSET_W{1'b0}}};

    assign refill_we   = (state == REFILL) & mem_ack_i;
    assign word_we     = (state == IDLE) & cpu_req_i & cpu_write_i & hit;

    assign cpu_rdata_o = line_data[32*word_sel +: 32];
    // Gated by reset so the pipeline is never frozen while held in reset.
    assign cpu_stall_o = rst_i & ((state != IDLE) | (cpu_req_i & ~hit));

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .INDEX_W   (INDEX_W),
        .TAG_W     (TAG_W),
        .BLOCK_W   (BLOCK_W)
    ) u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .index       (index),
        .valid       (line_valid),
        .dirty       (line_dirty),
        .tag         (line_tag),
        .data        (line_data),
        .refill_we   (refill_we),
        .refill_tag  (req_tag),
        .refill_data (mem_data_i),
        .word_we     (word_we),
        .word_sel    (word_sel),
        .word_data   (cpu_wdata_i)
    );

    // Miss sequencer with registered memory-side request outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu_req_i && !hit) begin
                        mem_enable_o <= 1'b1;
                        if (line_valid && line_dirty) begin
                            state       <= WRITEBACK;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= victim_addr;
                            mem_data_o  <= line_data;
                        end else begin
                            state       <= REFILL;
                            mem_write_o <= 1'b0;
                            mem_addr_o  <= req_addr;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state       <= REFILL;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= req_addr;
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        state        <= IDLE;
                        mem_enable_o <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    mem_enable_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Randomized bench for dcache_controller against a memory-level model.
// Model tracks architectural memory, backing memory and line residency.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_write_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] arch    [logic [31:0]];
    logic [31:0] backing [logic [31:0]];
    bit          m_valid [16];
    bit          m_dirty [16];
    logic [22:0] m_tag   [16];

    dcache_controller dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cpu_req_i    (cpu_req_i),
        .cpu_write_i  (cpu_write_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_rdata_o  (cpu_rdata_o),
        .cpu_stall_o  (cpu_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] wa);
        if (!arch.exists(wa)) begin
            logic [31:0] v = $urandom;
            arch[wa]    = v;
            backing[wa] = v;
        end
        return arch[wa];
    endfunction

    function automatic logic [255:0] blk(input bit from_arch,
                                         input logic [31:0] base);
        logic [255:0] b;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] w = base + 32'(4 * i);
            void'(rd_word(w));
            b[32*i +: 32] = from_arch ? arch[w] : backing[w];
        end
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        arch = backing;
    endtask

    // One CPU access from posedge+1 until the cycle it completes.
    task automatic access(input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input int dly);
        logic [31:0] wa    = a & 32'hFFFF_FFFC;
        int          idx   = int'((a >> 5) % 16);
        logic [22:0] tg    = 23'(a >> 9);
        bit          hit   = m_valid[idx] && (m_tag[idx] == tg);
        bit          wb    = !hit && m_valid[idx] && m_dirty[idx];
        logic [31:0] vbase = (32'(m_tag[idx]) << 9) | (32'(idx) << 5);
        logic [31:0] rbase = a & 32'hFFFF_FFE0;
        cpu_req_i   = 1'b1;
        cpu_write_i = wr;
        cpu_addr_i  = a;
        cpu_wdata_i = d;
        @(negedge clk_i);
        chk("stall_first", cpu_stall_o, !hit);
        if (!hit) begin
            chk("en_first", mem_enable_o, 1'b0);
            for (int p = (wb ? 0 : 1); p < 2; p++) begin
                int n = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
                for (int c = 0; c <= n; c++) begin
                    @(negedge clk_i);
                    mem_ack_i = 1'b0;
                    chk("stall_miss", cpu_stall_o, 1'b1);
                    chk("mem_en", mem_enable_o, 1'b1);
                    if (c == 0) begin
                        chk("mem_wr", mem_write_o, p == 0);
                        chk("mem_addr", mem_addr_o, (p == 0) ? vbase : rbase);
                        if (p == 0)
                            chk("wb_data", mem_data_o, blk(1'b1, vbase));
                    end
                    if (c == n) begin
                        mem_ack_i = 1'b1;
                        if (p == 0) begin
                            for (int i = 0; i < 8; i++)
                                backing[vbase + 32'(4*i)] = arch[vbase + 32'(4*i)];
                        end else begin
                            mem_data_i = blk(1'b0, rbase);
                        end
                    end
                end
            end
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            mem_data_i = {8{$urandom}};
            chk("stall_done", cpu_stall_o, 1'b0);
            chk("en_done", mem_enable_o, 1'b0);
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
        end
        if (wr) begin
            void'(rd_word(wa));
            arch[wa]     = d;
            m_dirty[idx] = 1'b1;
        end else begin
            chk("rdata", cpu_rdata_o, rd_word(wa));
        end
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b0;
        cpu_req_i   = 1'b0;
        cpu_write_i = 1'b0;
        cpu_addr_i  = '0;
        cpu_wdata_i = '0;
        mem_data_i  = '0;
        mem_ack_i   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_i);
        chk("rst_en", mem_enable_o, 1'b0);
        chk("rst_wr", mem_write_o, 1'b0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_data", mem_data_o, 256'h0);
        chk("rst_stall", cpu_stall_o, 1'b0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        access(1'b0, 32'h0000_0000, 32'h0, -1);
        arch[32'h100]    = 32'hDEAD_BEEF;
        backing[32'h100] = 32'hDEAD_BEEF;
        access(1'b0, 32'h0000_0100, 32'h0, 10);
        access(1'b1, 32'h0000_0104, 32'h1234_5678, -1);
        access(1'b0, 32'h0000_0104, 32'h0, -1);
        chk("word1", blk(1'b1, 32'h100) >> 32, 256'(32'h1234_5678) | (blk(1'b1, 32'h100) >> 64) << 32);
        access(1'b0, 32'h0000_0300, 32'h0, 2);
        access(1'b0, 32'h0000_0500, 32'h0, 1);

        mem_ack_i = 1'b1;
        @(negedge clk_i);
        chk("stray_en", mem_enable_o, 1'b0);
        chk("stray_stall", cpu_stall_o, 1'b0);
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("stray_en2", mem_enable_o, 1'b0);
        @(posedge clk_i);
        #1;
        access(1'b0, 32'h0000_0504, 32'h0, -1);

        cpu_req_i   = 1'b1;
        cpu_write_i = 1'b0;
        cpu_addr_i  = 32'h0000_0100;
        @(negedge clk_i);
        chk("r6_stall", cpu_stall_o, 1'b1);
        repeat (3) @(negedge clk_i);
        chk("r6_en_busy", mem_enable_o, 1'b1);
        #2;
        rst_i     = 1'b0;
        cpu_req_i = 1'b0;
        #1;
        chk("r6_en_drop", mem_enable_o, 1'b0);
        chk("r6_stall_drop", cpu_stall_o, 1'b0);
        model_reset();
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        access(1'b0, 32'h0000_0100, 32'h0, -1);

        for (int k = 0; k < 400; k++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 5)
              | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            access(1'($urandom_range(0, 1)), a, $urandom, -1);
            if ($urandom_range(0, 3) == 0) begin
                cpu_addr_i = $urandom;
                @(negedge clk_i);
                chk("idle_stall", cpu_stall_o, 1'b0);
                @(posedge clk_i);
                #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
